mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and RAM-side signals around mem_arbiter.
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    output if_rdata, if_done, d_rdata, d_done, ram_addr, ram_we, ram_din, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    input  if_rdata, if_done, d_rdata, d_done, ram_addr, ram_we, ram_din, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between a fetch port and a data port, one access per 4 cycles.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise data always wins.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input logic          CCLK,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          any_req;
  logic          grant_data;
  logic          owner_data;
  logic          write_flag;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  assign any_req = bus.if_req || bus.d_req;

`ifdef ARB_RR_EN
  // Remembers who was granted last so a tie goes to the other port.
  logic last_data;

  always_ff @(posedge CCLK) begin
    if (reset) begin
      last_data <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_data <= grant_data;
    end
  end

  always_comb begin
    grant_data = bus.d_req;
    if (bus.if_req && bus.d_req) begin
      grant_data = !last_data;
    end
  end
`else
  assign grant_data = bus.d_req;
`endif

  always_ff @(posedge CCLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ram_we and done are gated by reset so an abandoned transaction never commits or completes.
  always_comb begin
    state_next  = state;
    bus.ram_we  = 1'b0;
    bus.if_done = 1'b0;
    bus.d_done  = 1'b0;
    bus.busy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
        bus.ram_we = owner_data && write_flag && !reset;
      end
      RESP: begin
        state_next = DONE;
      end
      DONE: begin
        state_next  = IDLE;
        bus.if_done = !owner_data && !reset;
        bus.d_done  = owner_data && !reset;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      owner_data <= 1'b0;
      write_flag <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner_data <= grant_data;
        write_flag <= grant_data && bus.d_we;
        ram_addr_q <= grant_data ? bus.d_addr : bus.if_addr;
        if (grant_data) begin
          ram_din_q <= bus.d_wdata;
        end
      end
      // RAM output is valid during RESP, one cycle after the address was presented in ACCESS.
      if (state == RESP && !write_flag) begin
        if (owner_data) begin
          d_rdata_q <= bus.ram_dout;
        end else begin
          if_rdata_q <= bus.ram_dout;
        end
      end
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, hand-written corner sequences, and a
// randomized run against a transaction-level reference model (honours ARB_RR_EN).
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic          is_data;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic CCLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CCLK (CCLK),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic          model_last_d;
  logic          f_pend, d_pend, fr, dr, act, m_d, m_we, d_we_r;
  logic [AW-1:0] f_addr, d_addr_r, m_addr;
  logic [DW-1:0] d_wdata_r, m_wd, m_rd, exp_if, exp_d, old_ram3;
  int            g, next_free;
  vec_t          vecs [9];
  vec_t          single_rd;

  initial begin
    CCLK = 1'b0;
    forever #5 CCLK = ~CCLK;
  end

  // Behavioural single-port RAM with 1-cycle read latency plus a bench-only preload port.
  always @(posedge CCLK) begin
    if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_din;
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end
    bus.ram_dout <= ram[bus.ram_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge CCLK);
    #1;
  endtask

  function automatic logic pickData(input logic f_r, input logic d_r, input logic last_d);
    logic rr_on;
`ifdef ARB_RR_EN
    rr_on = 1'b1;
`else
    rr_on = 1'b0;
`endif
    if (f_r && d_r && rr_on) return !last_d;
    return d_r;
  endfunction

  task automatic expectCycle(input string name, input logic eb, input logic eif, input logic ed);
    @(negedge CCLK);
    checkOutput({name, " busy"}, bus.busy, eb);
    checkOutput({name, " if_done"}, bus.if_done, eif);
    checkOutput({name, " d_done"}, bus.d_done, ed);
    nextCycle();
  endtask

  // Runs one transaction from an IDLE cycle and returns in the IDLE cycle after it.
  task automatic applyStimulus(input vec_t v, input string name);
    int   n;
    int   we_cycles;
    logic seen;
    logic other_done;
    if (v.is_data) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    n = 0;
    we_cycles = 0;
    seen = 1'b0;
    other_done = 1'b0;
    while (!seen && n < 12) begin
      @(negedge CCLK);
      n++;
      if (bus.ram_we) begin
        we_cycles++;
        checkOutput({name, " ram_addr"}, bus.ram_addr, v.addr);
        checkOutput({name, " ram_din"}, bus.ram_din, v.wdata);
      end
      if (v.is_data ? bus.if_done : bus.d_done) other_done = 1'b1;
      seen = v.is_data ? bus.d_done : bus.if_done;
      if (!seen) nextCycle();
    end
    checkOutput({name, " latency"}, n, 4);
    checkOutput({name, " rdata"}, v.is_data ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
    checkOutput({name, " ram_we cycles"}, we_cycles, (v.is_data && v.we) ? 1 : 0);
    checkOutput({name, " other done"}, other_done, 1'b0);
    nextCycle();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge CCLK);
    checkOutput({name, " busy after"}, bus.busy, 1'b0);
    nextCycle();
  endtask

  task automatic pairTxn(input string name);
    logic first_d;
    first_d = pickData(1'b1, 1'b1, model_last_d);
    $display("[TB] %s: last owner %s, expecting %s first", name,
             model_last_d ? "data" : "fetch", first_d ? "data" : "fetch");
    bus.if_req  = 1'b1;
    bus.if_addr = 8'd5;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 8'd9;
    expectCycle({name, " idle"}, 1'b0, 1'b0, 1'b0);
    expectCycle({name, " access1"}, 1'b1, 1'b0, 1'b0);
    expectCycle({name, " resp1"}, 1'b1, 1'b0, 1'b0);
    expectCycle({name, " first done"}, 1'b1, !first_d, first_d);
    model_last_d = first_d;
    if (first_d) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    expectCycle({name, " gap"}, 1'b0, 1'b0, 1'b0);
    expectCycle({name, " access2"}, 1'b1, 1'b0, 1'b0);
    expectCycle({name, " resp2"}, 1'b1, 1'b0, 1'b0);
    expectCycle({name, " second done"}, 1'b1, first_d, !first_d);
    model_last_d = !first_d;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    expectCycle({name, " end"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Fields: is_data, we, addr, wdata, expected rdata of that port afterwards.
    vecs[0] = '{1'b0, 1'b0, 8'd5,   32'h0,        32'h11223344};
    vecs[1] = '{1'b1, 1'b1, 8'd9,   32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 8'd9,   32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 8'd9,   32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 8'd255, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 8'd255, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b1, 1'b0, 8'd5,   32'h0,        32'h11223344};
    vecs[7] = '{1'b1, 1'b1, 8'd0,   32'h0BADF00D, 32'h11223344};
    vecs[8] = '{1'b0, 1'b0, 8'd0,   32'h0,        32'h0BADF00D};
    single_rd = '{1'b1, 1'b0, 8'd9, 32'h0, 32'hDEADBEEF};

    reset       = 1'b1;
    bd_we       = 1'b0;
    bd_addr     = '0;
    bd_data     = '0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    model_last_d = 1'b0;
    nextCycle();

    bd_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bd_addr = 8'(a);
      bd_data = (a == 5) ? 32'h11223344 : (a == 3) ? 32'h33333333 : $urandom;
      nextCycle();
    end
    bd_we = 1'b0;

    @(negedge CCLK);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset if_done", bus.if_done, 1'b0);
    checkOutput("reset d_done", bus.d_done, 1'b0);
    checkOutput("reset ram_we", bus.ram_we, 1'b0);
    checkOutput("reset ram_addr", bus.ram_addr, 0);
    checkOutput("reset ram_din", bus.ram_din, 0);
    checkOutput("reset if_rdata", bus.if_rdata, 0);
    checkOutput("reset d_rdata", bus.d_rdata, 0);
    nextCycle();
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Data request raised while a fetch is in RESP.
    bus.if_req  = 1'b1;
    bus.if_addr = 8'd5;
    expectCycle("late idle", 1'b0, 1'b0, 1'b0);
    expectCycle("late access", 1'b1, 1'b0, 1'b0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'd9;
    expectCycle("late resp", 1'b1, 1'b0, 1'b0);
    expectCycle("late fetch done", 1'b1, 1'b1, 1'b0);
    checkOutput("late if_rdata", bus.if_rdata, 32'h11223344);
    bus.if_req = 1'b0;
    expectCycle("late gap", 1'b0, 1'b0, 1'b0);
    expectCycle("late d access", 1'b1, 1'b0, 1'b0);
    expectCycle("late d resp", 1'b1, 1'b0, 1'b0);
    expectCycle("late d done", 1'b1, 1'b0, 1'b1);
    checkOutput("late d_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_req = 1'b0;
    expectCycle("late end", 1'b0, 1'b0, 1'b0);

    // Reset during ACCESS of a write to address 3.
    old_ram3    = ram[3];
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'd3;
    bus.d_wdata = 32'hCAFEF00D;
    nextCycle();
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(negedge CCLK);
    checkOutput("abort ram_we gated", bus.ram_we, 1'b0);
    nextCycle();
    reset = 1'b0;
    @(negedge CCLK);
    checkOutput("abort ram_addr", bus.ram_addr, 0);
    checkOutput("abort ram_din", bus.ram_din, 0);
    checkOutput("abort if_rdata", bus.if_rdata, 0);
    checkOutput("abort d_rdata", bus.d_rdata, 0);
    checkOutput("abort ram_we", bus.ram_we, 1'b0);
    checkOutput("abort ram3", ram[3], old_ram3);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      expectCycle($sformatf("abort quiet%0d", i), 1'b0, 1'b0, 1'b0);
    end
    model_last_d = 1'b0;

    pairTxn("pair1");
    pairTxn("pair2");
    applyStimulus(single_rd, "solo data");
    model_last_d = 1'b1;
    pairTxn("pair3");

    // Randomized traffic against the transaction-level model.
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    for (int a = 0; a < 256; a++) ref_mem[a] = ram[a];
    act = 1'b0; g = 0; next_free = 0; model_last_d = 1'b0;
    exp_if = '0; exp_d = '0; m_d = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    f_pend = 1'b0; d_pend = 1'b0; f_addr = '0; d_addr_r = '0; d_wdata_r = '0; d_we_r = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1;
        f_addr = 8'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend    = 1'b1;
        d_we_r    = 1'($urandom);
        d_addr_r  = 8'($urandom_range(0, 15));
        d_wdata_r = $urandom;
      end
      fr = f_pend;
      dr = d_pend;
      bus.if_req  = fr;
      bus.if_addr = f_addr;
      bus.d_req   = dr;
      bus.d_we    = d_we_r;
      bus.d_addr  = d_addr_r;
      bus.d_wdata = d_wdata_r;
      if (act && cyc == g + 2 && !m_we) begin
        if (m_d) exp_d = m_rd;
        else exp_if = m_rd;
      end
      @(negedge CCLK);
      checkOutput("rnd busy", bus.busy, act && cyc >= g && cyc <= g + 2);
      checkOutput("rnd ram_we", bus.ram_we, act && cyc == g && m_we);
      checkOutput("rnd if_done", bus.if_done, act && cyc == g + 2 && !m_d);
      checkOutput("rnd d_done", bus.d_done, act && cyc == g + 2 && m_d);
      checkOutput("rnd if_rdata", bus.if_rdata, exp_if);
      checkOutput("rnd d_rdata", bus.d_rdata, exp_d);
      if (act && cyc == g) checkOutput("rnd ram_addr", bus.ram_addr, m_addr);
      if (act && cyc == g && m_we) checkOutput("rnd ram_din", bus.ram_din, m_wd);
      if (bus.if_done) f_pend = 1'b0;
      if (bus.d_done) d_pend = 1'b0;
      if (cyc >= next_free && (fr || dr)) begin
        m_d          = pickData(fr, dr, model_last_d);
        model_last_d = m_d;
        act          = 1'b1;
        g            = cyc + 1;
        next_free    = cyc + 4;
        m_addr       = m_d ? d_addr_r : f_addr;
        m_we         = m_d && d_we_r;
        m_wd         = d_wdata_r;
        if (m_we) ref_mem[m_addr] = m_wd;
        else m_rd = ref_mem[m_addr];
      end
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
